fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/fifo_uart_tx.sv | 101 ++++++++++
 tb/tb_fifo_uart_tx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding and default sizing.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 4;
  localparam int DATA_W_DEF       = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  // States whose duration is measured in bit periods.
  function automatic logic is_timed(input tx_state_e s);
    return (s == ST_START) || (s == ST_DATA) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, flags the last and next-to-last cycle.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

  assign tick     = en && (cnt == CNT_LAST);
  // One cycle of warning lets the parent register outputs that land on the final cycle.
  assign pre_tick = en && (cnt == CNT_PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from an upstream FIFO; all outputs are flops.
import uart_pkg::*;

module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  tx_state_e         state, state_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic              tx_nxt, rd_nxt, done_nxt;
  logic              timed, tick, pre_tick;

  assign timed = is_timed(state);
  assign busy  = (state != ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .en       (timed),
    .clr      (!timed),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_nxt;
      shift      <= shift_nxt;
      tx         <= tx_nxt;
      fifo_rd    <= rd_nxt;
      frame_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    unique case (state)
      ST_IDLE:  if (fifo_rd) state_nxt = ST_FETCH;
      ST_FETCH: begin
        shift_nxt = fifo_dout;
        state_nxt = ST_START;
      end
      ST_START: if (tick) begin
        state_nxt = ST_DATA;
        bit_nxt   = '0;
      end
      ST_DATA: if (tick) begin
        shift_nxt = shift >> 1;
        if (bit_cnt == BIT_LAST) begin
          state_nxt = ST_STOP;
          bit_nxt   = '0;
        end else begin
          bit_nxt = bit_cnt + 1'b1;
        end
      end
      ST_STOP:  if (tick) state_nxt = fifo_rd ? ST_FETCH : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output flops are loaded with the value belonging to the next cycle.
  // The pop is requested one cycle ahead: fifo_empty can only rise through our own pop,
  // so a non-empty flag seen now is still non-empty when the strobe appears.
  always_comb begin
    rd_nxt   = !fifo_empty && !fifo_rd &&
               ((state == ST_IDLE) || ((state == ST_STOP) && (pre_tick || tick)));
    done_nxt = (state == ST_STOP) && pre_tick;
    unique case (state_nxt)
      ST_START: tx_nxt = 1'b0;
      ST_DATA:  tx_nxt = shift_nxt[0];
      default:  tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: behavioural FIFO, UART receiver model and cycle-exact vectors.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fifo_dout = '0;
  logic       fifo_empty;
  logic       fifo_rd, tx, busy, frame_done;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // 8-deep FIFO; data appears on fifo_dout the cycle after a pop strobe.
  logic [7:0] fmem [8];
  int fcnt = 0, fwp = 0, frp = 0;
  assign fifo_empty = (fcnt == 0);
  always @(posedge clk) begin
    if (fifo_rd && fcnt > 0) begin
      fifo_dout <= fmem[frp];
      frp <= (frp + 1) % 8;
    end
    if (wr_en) begin
      fmem[fwp] <= wr_data;
      fwp <= (fwp + 1) % 8;
    end
    fcnt <= fcnt + (wr_en ? 1 : 0) - ((fifo_rd && fcnt > 0) ? 1 : 0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake monitor.
  int   proto_err = 0, rd_pulses = 0;
  logic rd_prev = 1'b0;
  always @(negedge clk) begin
    if (fifo_rd && fifo_empty) $display("FAIL rd_empty: fifo_rd=1 while fifo_empty=1 at cycle %0d", cyc);
    if (fifo_rd && rd_prev) $display("FAIL rd_twice: fifo_rd high two cycles running at cycle %0d", cyc);
    proto_err <= proto_err + ((fifo_rd && fifo_empty) ? 1 : 0) + ((fifo_rd && rd_prev) ? 1 : 0);
    rd_pulses <= rd_pulses + (fifo_rd ? 1 : 0);
    rd_prev   <= fifo_rd;
  end

  a_rd_not_empty: assert property (@(posedge clk) disable iff (rst) fifo_rd |-> !fifo_empty)
    else $display("FAIL assert_rd_not_empty at cycle %0d", cyc);

  // Receiver: cycle 0 is the first low cycle, bits sampled mid-period.
  logic       rx_busy = 1'b0;
  int         rx_ph = 0, rx_ferr = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_bytes [$];
  int         rx_starts [$];
  always @(negedge clk) begin
    if (rst) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy <= 1'b1;
        rx_ph   <= 1;
        rx_starts.push_back(cyc);
      end
    end else begin
      rx_ph <= rx_ph + 1;
      if (rx_ph >= 6 && rx_ph <= 34 && (rx_ph % CPB) == 2) rx_sh <= {tx, rx_sh[7:1]};
      if (rx_ph == 38) begin
        if (tx !== 1'b1) begin
          $display("FAIL rx_stop: stop bit read %b, required 1", tx);
          rx_ferr <= rx_ferr + 1;
        end
        rx_bytes.push_back(rx_sh);
        rx_busy <= 1'b0;
      end
    end
  end

  int         n_cmp = 0, n_fail = 0;
  logic [7:0] all_exp [$];
  int         rx_rd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the write lands.
  task automatic push(input logic [7:0] d, input bit keep);
    wr_en   = 1'b1;
    wr_data = d;
    if (keep) all_exp.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (busy === lvl) break;
      @(negedge clk);
    end
    chk("wait_busy", busy, lvl);
  endtask

  task automatic check_rx();
    chk("rx_count", rx_bytes.size(), all_exp.size());
    for (int i = rx_rd; i < all_exp.size() && i < rx_bytes.size(); i++)
      chk($sformatf("rx_byte%0d", i), rx_bytes[i], all_exp[i]);
    rx_rd = all_exp.size();
    chk("rx_framing", rx_ferr, 0);
    chk("protocol", proto_err, 0);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [9:0] wave;  // serial line per bit period, index 0 = start bit
  } vec_t;
  vec_t vecs [5];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, rd0;
    vecs[0] = '{8'hA5, 10'h34A};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'h01, 10'h202};
    vecs[4] = '{8'h80, 10'h300};

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fifo_rd", fifo_rd, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("idle_empty", {busy, fifo_rd, tx}, 3'b001);
    end

    for (int v = 0; v < 5; v++) begin
      push(vecs[v].din, 1'b1);
      chk($sformatf("v%0d_rd_c0", v), fifo_rd, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_rd_c1", v), {busy, fifo_rd}, 2'b01);
      @(negedge clk);
      chk($sformatf("v%0d_fetch", v), {busy, fifo_rd, tx}, 3'b101);
      for (int b = 0; b < 10; b++) begin
        for (int k = 0; k < CPB; k++) begin
          @(negedge clk);
          chk($sformatf("v%0d_bit%0d_tx", v, b), tx, vecs[v].wave[b]);
          chk($sformatf("v%0d_bit%0d_done", v, b), frame_done, (b == 9 && k == CPB - 1));
          if (k == 0) chk($sformatf("v%0d_bit%0d_busy", v, b), {busy, fifo_rd}, 2'b10);
        end
      end
      @(negedge clk);
      chk($sformatf("v%0d_end", v), {busy, tx, frame_done}, 3'b010);
    end
    repeat (3) @(negedge clk);
    check_rx();

    // Four bytes queued back to back.
    s0  = rx_starts.size();
    rd0 = rd_pulses;
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'hAA + 8'(i * 8'h11);
      all_exp.push_back(wr_data);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_busy(1'b1, 10);
    wait_busy(1'b0, 250);
    repeat (3) @(negedge clk);
    chk("b2b_rd_pulses", rd_pulses - rd0, 4);
    chk("b2b_frames", rx_starts.size() - s0, 4);
    for (int i = 1; i < 4 && s0 + i < rx_starts.size(); i++)
      chk($sformatf("b2b_spacing%0d", i), rx_starts[s0 + i] - rx_starts[s0 + i - 1], 41);
    chk("b2b_idle", {busy, fifo_rd, tx}, 3'b001);
    check_rx();

    // Byte arriving during the stop bit chains straight into FETCH.
    s0 = rx_starts.size();
    push(8'h11, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (fifo_rd) break;
      @(negedge clk);
    end
    chk("stop_first_rd", fifo_rd, 1'b1);
    repeat (38) @(negedge clk);
    chk("stop_entry", {busy, tx, frame_done}, 3'b110);
    push(8'h22, 1'b1);
    chk("stop_c40", {fifo_rd, frame_done}, 2'b00);
    @(negedge clk);
    chk("stop_c41", {fifo_rd, frame_done}, 2'b00);
    @(negedge clk);
    chk("stop_last", {fifo_rd, frame_done, busy}, 3'b111);
    @(negedge clk);
    chk("stop_fetch", {busy, tx, fifo_rd}, 3'b110);
    @(negedge clk);
    chk("stop_next_start", {busy, tx}, 2'b10);
    wait_busy(1'b0, 100);
    repeat (3) @(negedge clk);
    chk("stop_frames", rx_starts.size() - s0, 2);
    if (s0 + 1 < rx_starts.size()) chk("stop_spacing", rx_starts[s0 + 1] - rx_starts[s0], 41);
    check_rx();

    // Reset in the middle of data bit 3 of 0x3C; the popped byte is lost.
    push(8'h3C, 1'b0);
    @(negedge clk);
    chk("rst_mid_rd", fifo_rd, 1'b1);
    repeat (19) @(negedge clk);
    chk("rst_mid_bit3", {busy, tx}, 2'b11);
    #2 rst = 1'b1;
    #1 chk("rst_mid_async", {tx, busy, fifo_rd, frame_done}, 4'b1000);
    @(negedge clk);
    push(8'h55, 1'b1);
    chk("rst_hold_rd0", {fifo_rd, busy, tx}, 3'b001);
    @(negedge clk);
    chk("rst_hold_rd1", {fifo_rd, busy, tx}, 3'b001);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_first_rd", fifo_rd, 1'b1);
    wait_busy(1'b1, 5);
    wait_busy(1'b0, 100);
    repeat (3) @(negedge clk);
    check_rx();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
